// File: rtl/bsg_axi4_mem_responder_if.sv
// AXI4 bus bundle between a master and the memory responder.
// The master drives the request channels and bready/rready; the slave drives the rest.
interface bsg_axi4_mem_responder_if #(
    parameter int id_width_p   = 4,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 64
);
    localparam int strb_width_lp = data_width_p / 8;

    logic [id_width_p-1:0]    awid;
    logic [addr_width_p-1:0]  awaddr;
    logic [7:0]               awlen;
    logic [2:0]               awsize;
    logic [1:0]               awburst;
    logic                     awvalid;
    logic                     awready;

    logic [data_width_p-1:0]  wdata;
    logic [strb_width_lp-1:0] wstrb;
    logic                     wlast;
    logic                     wvalid;
    logic                     wready;

    logic [id_width_p-1:0]    bid;
    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;

    logic [id_width_p-1:0]    arid;
    logic [addr_width_p-1:0]  araddr;
    logic [7:0]               arlen;
    logic [2:0]               arsize;
    logic [1:0]               arburst;
    logic                     arvalid;
    logic                     arready;

    logic [id_width_p-1:0]    rid;
    logic [data_width_p-1:0]  rdata;
    logic [1:0]               rresp;
    logic                     rlast;
    logic                     rvalid;
    logic                     rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        output rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        input  rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/bsg_axi4_mem_responder.sv
// AXI4 slave memory model: single-ported synchronous storage serving one INCR burst at a time.
// Read data is registered, so the first beat appears two cycles after the AR handshake.
module bsg_axi4_mem_responder #(
    parameter int axi_id_width_p   = 4,
    parameter int axi_addr_width_p = 32,
    parameter int axi_data_width_p = 64,
    parameter int mem_els_p        = 64
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    bsg_axi4_mem_responder_if.slave        s_axi4_bus,
    output logic                           error_o
);
    localparam int data_bytes_lp    = axi_data_width_p / 8;
    localparam int lg_data_bytes_lp = $clog2(data_bytes_lp);
    localparam int lg_els_lp        = $clog2(mem_els_p);
    localparam logic [2:0] size_lp  = 3'(lg_data_bytes_lp);

    localparam logic [1:0] idle_s  = 2'd0;
    localparam logic [1:0] wdata_s = 2'd1;
    localparam logic [1:0] wresp_s = 2'd2;
    localparam logic [1:0] rdata_s = 2'd3;

    logic [1:0]                  state_q,   state_d;
    logic                        prio_q,    prio_d;     // 0: write wins a tie
    logic                        awready_q, awready_d;
    logic                        arready_q, arready_d;
    logic                        bvalid_q,  bvalid_d;
    logic                        rvalid_q,  rvalid_d;
    logic                        rlast_q,   rlast_d;
    logic [axi_id_width_p-1:0]   id_q,      id_d;
    logic [lg_els_lp-1:0]        idx_q,     idx_d;
    logic [7:0]                  len_q,     len_d;
    logic [8:0]                  cnt_q,     cnt_d;
    logic                        error_q,   error_d;
    logic [axi_data_width_p-1:0] rdata_q;
    logic [axi_data_width_p-1:0] mem_q [mem_els_p];

    logic aw_hs, ar_hs, w_hs, b_hs, r_hs, rd_issue;
    assign aw_hs    = awready_q & s_axi4_bus.awvalid;
    assign ar_hs    = arready_q & s_axi4_bus.arvalid;
    assign w_hs     = (state_q == wdata_s) & s_axi4_bus.wvalid;
    assign b_hs     = bvalid_q & s_axi4_bus.bready;
    assign r_hs     = rvalid_q & s_axi4_bus.rready;
    // Fetch the next beat whenever the output register is empty or draining.
    assign rd_issue = (state_q == rdata_s) && (!rvalid_q || s_axi4_bus.rready)
                      && (cnt_q <= {1'b0, len_q});

    // Burst type and the aliased upper address bits are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{s_axi4_bus.awaddr, s_axi4_bus.araddr,
                           s_axi4_bus.awburst, s_axi4_bus.arburst};

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first, so no latch is inferred.
        state_d   = state_q;
        prio_d    = prio_q;
        awready_d = awready_q;
        arready_d = arready_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        id_d      = id_q;
        idx_d     = idx_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        error_d   = error_q;
        case (state_q)
            idle_s: begin
                awready_d = 1'b0;
                arready_d = 1'b0;
                if (aw_hs) begin
                    state_d = wdata_s;
                    prio_d  = ~prio_q;
                    id_d    = s_axi4_bus.awid;
                    idx_d   = s_axi4_bus.awaddr[lg_data_bytes_lp +: lg_els_lp];
                    len_d   = s_axi4_bus.awlen;
                    cnt_d   = '0;
                    if (s_axi4_bus.awsize != size_lp) error_d = 1'b1;
                end else if (ar_hs) begin
                    state_d = rdata_s;
                    prio_d  = ~prio_q;
                    id_d    = s_axi4_bus.arid;
                    idx_d   = s_axi4_bus.araddr[lg_data_bytes_lp +: lg_els_lp];
                    len_d   = s_axi4_bus.arlen;
                    cnt_d   = '0;
                    if (s_axi4_bus.arsize != size_lp) error_d = 1'b1;
                end else if (!awready_q && !arready_q) begin
                    if (s_axi4_bus.awvalid && (!s_axi4_bus.arvalid || !prio_q))
                        awready_d = 1'b1;
                    else if (s_axi4_bus.arvalid)
                        arready_d = 1'b1;
                end
            end
            wdata_s: begin
                if (w_hs) begin
                    cnt_d = cnt_q + 9'd1;
                    idx_d = idx_q + 1'b1;
                    // The beat counter ends the burst; wlast is only cross-checked.
                    if (cnt_q[7:0] == len_q) begin
                        state_d  = wresp_s;
                        bvalid_d = 1'b1;
                        if (!s_axi4_bus.wlast) error_d = 1'b1;
                    end else if (s_axi4_bus.wlast) begin
                        error_d = 1'b1;
                    end
                end
            end
            wresp_s: begin
                if (b_hs) begin
                    bvalid_d = 1'b0;
                    state_d  = idle_s;
                end
            end
            default: begin
                if (rd_issue) begin
                    rvalid_d = 1'b1;
                    rlast_d  = (cnt_q[7:0] == len_q);
                    cnt_d    = cnt_q + 9'd1;
                    idx_d    = idx_q + 1'b1;
                end else if (r_hs) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) state_d = idle_s;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            state_q   <= idle_s;
            prio_q    <= 1'b0;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            id_q      <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            error_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            awready_q <= awready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            id_q      <= id_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            error_q   <= error_d;
            if (rd_issue) rdata_q <= mem_q[idx_q];
        end
    end

    // NOTE: storage has no reset, so its contents survive reset_i and it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (w_hs) begin
            for (int b = 0; b < data_bytes_lp; b++) begin
                if (s_axi4_bus.wstrb[b]) mem_q[idx_q][b*8 +: 8] <= s_axi4_bus.wdata[b*8 +: 8];
            end
        end
    end

    assign s_axi4_bus.awready = awready_q;
    assign s_axi4_bus.arready = arready_q;
    assign s_axi4_bus.wready  = (state_q == wdata_s);
    assign s_axi4_bus.bvalid  = bvalid_q;
    assign s_axi4_bus.bid     = id_q;
    assign s_axi4_bus.bresp   = 2'b00;
    assign s_axi4_bus.rvalid  = rvalid_q;
    assign s_axi4_bus.rid     = id_q;
    assign s_axi4_bus.rdata   = rdata_q;
    assign s_axi4_bus.rresp   = 2'b00;
    assign s_axi4_bus.rlast   = rlast_q;
    assign error_o            = error_q;
endmodule
